serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial unsigned subtractor: computes diff = a - b (mod 2^WIDTH) one bit per clock, LSB first.
//   It is the inverse arithmetic path to the ripple adder.
//   It is used where a TPU datapath needs a cheap multi-cycle subtract or compare, e.g. accumulator
//   drain, bias removal or threshold checks.
//   Valid/ready handshake on both the operand side and the result side.
//
// PARAMETERS
//   WIDTH  4  operand/result width in bits; legal range WIDTH >= 1
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operands a/b are valid
//   in_ready   out  1      block accepts operands (high only in IDLE)
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   out_valid  out  1      diff/borrow/zero are valid
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  a - b mod 2^WIDTH
//   borrow     out  1      1 iff a < b (unsigned)
//   zero       out  1      1 iff diff == 0
//
// BEHAVIOUR
//   - FSM states: IDLE, CALC, DONE.
//   - Reset: rst high asynchronously forces state=IDLE and clears every register (shift regs, borrow
//     FF, counter, diff, borrow, zero) to 0. Outputs during/after reset: in_ready=1, out_valid=0,
//     diff=0, borrow=0, zero=0.
//   - IDLE: in_ready=1.
//     On the edge where in_valid && in_ready: load a_sh<=a, b_sh<=b, bor<=0, cnt<=0, then go to CALC.
//   - CALC: in_ready=0, out_valid=0. Each edge:
//     - d      = a_sh[0] ^ b_sh[0] ^ bor
//     - bor    <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor)
//     - diff_sh <= {d, diff_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1
//     - cnt <= cnt + 1
//     - When cnt == WIDTH-1: register the final diff, borrow = bor_next and zero = (final diff == 0),
//       then go to DONE.
//   - DONE: out_valid=1; diff/borrow/zero held stable while out_ready=0.
//     On the edge where out_valid && out_ready, go to IDLE.
//   - Latency: accept edge E -> out_valid high after edge E+WIDTH.
//     Min initiation interval WIDTH+2 cycles (no accept in DONE).
//   - in_valid while in CALC or DONE is ignored; operands are not captured. Upstream must hold them
//     until in_ready.
//   - diff/borrow/zero retain the last result in IDLE/CALC; they are meaningful only while out_valid=1.
//   - Wrap-around: a < b yields the two's-complement wrap (e.g. 3-9 -> 4'hA) with borrow=1.
//   - WIDTH=1: CALC lasts exactly one edge.
//   - Counter width $clog2(WIDTH)+1; no overflow is possible.
//   - Reset mid-CALC or mid-DONE: the result is discarded, out_valid drops asynchronously, and the
//     block returns to IDLE.
//
// STRUCTURE
//   - Package sub_pkg: typedef enum logic [1:0] {IDLE, CALC, DONE} sub_state_t.
//   - Sub-module full_subtractor(a, b, bin, d, bout), purely combinational, one instance; it is the
//     dual of full_adder.
//   - The top level holds the FSM, shift registers, borrow FF, counter and output registers.
//
// TESTING
//   1. WIDTH=4, a=9, b=3, out_ready=1 -> out_valid after 4 clks; diff=6, borrow=0, zero=0.
//   2. a=3, b=9 -> diff=4'hA, borrow=1, zero=0.
//   3. a=5, b=5 -> diff=0, borrow=0, zero=1.
//      a=0, b=0 -> diff=0, zero=1.
//   4. Backpressure: out_ready=0 for 5 clks in DONE -> outputs stable, in_ready=0.
//      New in_valid with a=7, b=1 is ignored until IDLE; then the result is 6.
//   5. rst pulse at the 2nd CALC cycle -> out_valid never rises.
//      in_ready=1 immediately; the next op (a=15, b=0) gives diff=15.
//   6. WIDTH=8: 255-1 -> 254, borrow=0; 0-1 -> 8'hFF, borrow=1.
//      WIDTH=1: 0-1 -> diff=1, borrow=1.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   sub_state_t : controller state encoding (IDLE, CALC, DONE)
//   cnt_width() : bit count for the per-operation bit counter
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // One spare bit above $clog2 keeps WIDTH=1 legal (zero-width would be illegal)
  // and leaves headroom so the counter cannot wrap before the last compare.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor, the dual of a full adder.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   d    : difference bit
//   bout : borrow out to the next bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when the bits match and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
// LSB first, with valid/ready handshakes on operand and result sides.
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active-high
//   in_valid  : operands a/b valid
//   in_ready  : block accepts operands (IDLE only)
//   a, b      : minuend / subtrahend, unsigned
//   out_valid : diff/borrow/zero valid (DONE only)
//   out_ready : consumer takes result
//   diff      : a - b mod 2^WIDTH
//   borrow    : 1 iff a < b
//   zero      : 1 iff diff == 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1
// CALC  | one difference bit per clock, WIDTH clocks total
// DONE  | result presented with out_valid=1, held until out_ready
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  import sub_pkg::*;

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] diff_sh_next;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bor_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lines up as a normal binary word.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_sh_next = fs_d;
    end else begin : g_wn
      assign diff_sh_next = {fs_d, diff_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    bor_d     = bor_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = diff_sh_next;
        bor_d     = fs_bout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Final borrow out of the MSB is exactly the unsigned a < b flag.
          diff_d   = diff_sh_next;
          borrow_d = fs_bout;
          zero_d   = (diff_sh_next == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      bor_q     <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      bor_q     <= bor_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      zero_q    <= zero_d;
    end
  end

  // Decoded straight from the state flop so reset drops out_valid asynchronously.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, borrow4, zero4;
  logic [3:0] a4, b4, diff4;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8, zero8;
  logic [7:0] a8, b8, diff8;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1, zero1;
  logic [0:0] a1, b1, diff1;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .diff(diff4), .borrow(borrow4), .zero(zero4));
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8), .borrow(borrow8), .zero(zero8));
  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .diff(diff1), .borrow(borrow1), .zero(zero1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Behavioural model of the WIDTH=4 instance: one job at a time, result is
  // plain modular arithmetic, visible from WIDTH edges after acceptance until
  // the consumer takes it.
  bit  m_busy = 0;
  int  ec = 0;
  int  m_acc = 0;
  int  m_diff, m_bor, m_zero, dd;
  bit  exp_ov;

  always @(posedge clk) begin
    ec = ec + 1;
    if (rst) begin
      m_busy = 0;
    end else if (m_busy && ec > m_acc + 4 && out_ready4) begin
      m_busy = 0;
    end else if (!m_busy && in_valid4) begin
      m_busy = 1;
      m_acc  = ec;
      dd     = int'(a4) - int'(b4);
      m_bor  = (dd < 0) ? 1 : 0;
      if (dd < 0) dd = dd + 16;
      m_diff = dd;
      m_zero = (dd == 0) ? 1 : 0;
    end
    #1;
    if (rst) begin
      chk("rst_in_ready", int'(in_ready4), 1);
      chk("rst_out_valid", int'(out_valid4), 0);
      chk("rst_diff", int'(diff4), 0);
      chk("rst_borrow", int'(borrow4), 0);
      chk("rst_zero", int'(zero4), 0);
    end else begin
      exp_ov = m_busy && (ec >= m_acc + 4);
      chk("model_in_ready", int'(in_ready4), m_busy ? 0 : 1);
      chk("model_out_valid", int'(out_valid4), exp_ov ? 1 : 0);
      if (exp_ov) begin
        chk("model_diff", int'(diff4), m_diff);
        chk("model_borrow", int'(borrow4), m_bor);
        chk("model_zero", int'(zero4), m_zero);
      end
    end
  end

  // All drivers below are entered and left at a falling edge.
  task automatic send4(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    a4 = x; b4 = y; in_valid4 = 1'b1;
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("send4");
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic get4(input int hold, input bit lit, input int ed, input int eb, input int ez);
    int n = 0;
    while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("get4");
    else begin
      chk("latency4", n, 4);
      if (lit) begin
        chk("lit_diff4", int'(diff4), ed);
        chk("lit_borrow4", int'(borrow4), eb);
        chk("lit_zero4", int'(zero4), ez);
      end
    end
    repeat (hold) @(negedge clk);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input int ed, input int eb);
    int n = 0;
    a8 = x; b8 = y; in_valid8 = 1'b1;
    while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("op8");
    else begin
      chk("latency8", n, 8);
      chk("lit_diff8", int'(diff8), ed);
      chk("lit_borrow8", int'(borrow8), eb);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic op1(input logic [0:0] x, input logic [0:0] y, input int ed, input int eb);
    int n = 0;
    a1 = x; b1 = y; in_valid1 = 1'b1;
    while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("op1");
    else begin
      chk("latency1", n, 1);
      chk("lit_diff1", int'(diff1), ed);
      chk("lit_borrow1", int'(borrow1), eb);
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] x, y;
    rst = 1'b1;
    in_valid4 = 0; out_ready4 = 0; a4 = '0; b4 = '0;
    in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0;
    in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send4(4'd9, 4'd3);  get4(0, 1, 6, 0, 0);
    send4(4'd3, 4'd9);  get4(0, 1, 10, 1, 0);
    send4(4'd5, 4'd5);  get4(0, 1, 0, 0, 1);
    send4(4'd0, 4'd0);  get4(1, 1, 0, 0, 1);

    // Backpressure with a new request waiting upstream.
    send4(4'd9, 4'd3);
    begin
      int n = 0;
      while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("bp_wait");
    end
    a4 = 4'd7; b4 = 4'd1; in_valid4 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready4), 0);
      chk("bp_out_valid", int'(out_valid4), 1);
      chk("bp_diff", int'(diff4), 6);
    end
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    send4(4'd7, 4'd1);  get4(0, 1, 6, 0, 0);

    // Reset in the second CALC cycle discards the operation.
    send4(4'd9, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid4), 0);
    chk("midrst_in_ready", int'(in_ready4), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_valid", int'(out_valid4), 0);
    end
    send4(4'd15, 4'd0); get4(0, 1, 15, 0, 0);

    for (int i = 0; i < 30; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      if (i % 5 == 0) y = x;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send4(x, y);
      get4(int'($urandom_range(0, 3)), 0, 0, 0, 0);
    end

    op8(8'd255, 8'd1, 254, 0);
    op8(8'd0, 8'd1, 255, 1);
    op8(8'd100, 8'd37, 63, 0);
    op1(1'b0, 1'b1, 1, 1);
    op1(1'b1, 1'b1, 0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
